// File: rtl/seq_divider.sv
// Multicycle restoring divider (one quotient bit per cycle) producing MIPS div results on HI/LO.
// Optional unsigned mode (divu) is enabled by defining SEQ_DIVIDER_DIVU_EN.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_DIVU_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_zero_req;
  logic             w_step;
  logic             w_finish;
  logic             w_unsigned;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

`ifdef SEQ_DIVIDER_DIVU_EN
  assign w_unsigned = is_unsigned;
`else
  assign w_unsigned = 1'b0;
`endif

  // Magnitudes; abs(most-negative) wraps to itself, which is the correct unsigned magnitude.
  assign w_sign_a = dividend[WIDTH-1] & ~w_unsigned;
  assign w_sign_b = divisor[WIDTH-1] & ~w_unsigned;
  assign w_abs_a  = w_sign_a ? -dividend : dividend;
  assign w_abs_b  = w_sign_b ? -divisor : divisor;

  // The shifted remainder needs one extra bit; after a subtract it always fits WIDTH bits again.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvsr});
  assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvsr) : w_shift[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_req   = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_zero_req = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_finish     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvsr     <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (w_zero_req) begin
        r_done     <= 1'b1;
        r_div_zero <= 1'b1;
      end
      if (w_accept) begin
        r_quo   <= w_abs_a;
        r_dvsr  <= w_abs_b;
        r_rem   <= '0;
        r_cnt   <= CNT_W'(WIDTH);
        r_q_neg <= w_sign_a ^ w_sign_b;
        r_r_neg <= w_sign_a;
      end
      if (w_step) begin
        r_rem <= w_rem_next;
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_lo   <= r_q_neg ? -r_quo : r_quo;
        r_hi   <= r_r_neg ? -r_rem : r_rem;
        r_done <= 1'b1;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule
